// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port image RAM between the fill/upscale
// writer (m0) and the readout/checksum reader (m1). Ownership is granted in
// whole tenures of up to MAX_BURST accesses. Ties are broken round-robin using
// the master that last gave the RAM up. RAM strobes are steered combinationally
// from the owning master, so an access takes effect in the cycle it is presented.
module ram_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_D,
  output logic          RAM_WE,
  output logic          RAM_OE,
  input  logic [DW-1:0] RAM_Q
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          last_owner, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          acc0, acc1;
  logic          burst_end;

  // Grants come straight from the state register, so they are glitch-free.
  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign acc0      = m0_gnt & m0_req;
  assign acc1      = m1_gnt & m1_req;
  assign burst_end = (cnt == CW'(MAX_BURST - 1));

  // The RAM reads its data one cycle after OE, so it is returned without modification.
  assign rdata = RAM_Q;

  // Steer the owning master's access onto the RAM pins; the pins sit at zero when no access is issued.
  always_comb begin
    RAM_A  = '0;
    RAM_D  = '0;
    RAM_WE = 1'b0;
    RAM_OE = 1'b0;
    if (acc0) begin
      RAM_A  = m0_addr;
      RAM_D  = m0_wdata;
      RAM_WE = m0_we;
      RAM_OE = ~m0_we;
    end else if (acc1) begin
      RAM_A  = m1_addr;
      RAM_D  = m1_wdata;
      RAM_WE = m1_we;
      RAM_OE = ~m1_we;
    end
  end

  // Decide the next owner: round-robin on ties, handover when the owner is done or its burst budget runs out.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0_req && m1_req) begin
          state_nxt = last_owner ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_nxt = OWN0;
        end else if (m1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
          state_nxt = m1_req ? OWN1 : IDLE;
        end else if (burst_end) begin
          cnt_nxt = '0;
          if (m1_req) begin
            last_nxt  = 1'b0;
            state_nxt = OWN1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OWN1: begin
        if (!m1_req) begin
          cnt_nxt   = '0;
          last_nxt  = 1'b1;
          state_nxt = m0_req ? OWN0 : IDLE;
        end else if (burst_end) begin
          cnt_nxt = '0;
          if (m0_req) begin
            last_nxt  = 1'b1;
            state_nxt = OWN0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Ownership state and burst count registers; last_owner=1 after reset so m0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Remember who issued a read, so the data goes back to that master even if ownership changed at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= acc0 & ~m0_we;
      m1_rvalid <= acc1 & ~m1_we;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios with literal expectations, followed by a
// randomized phase. A tenure-level reference model is checked against the DUT on every cycle.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic          RAM_WE, RAM_OE;
  logic [DW-1:0] RAM_Q;

  int n_compared   = 0;
  int n_mismatched = 0;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_OE(RAM_OE), .RAM_Q(RAM_Q)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // The power-up contents of the RAM image. Address 0x1234 holds 0xAB, and every other address holds its high byte XOR its low byte.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hAB : (a[7:0] ^ a[15:8]);
  endfunction

  // Behavioural RAM macro: a synchronous write, and read data that appears one cycle after OE. It fills itself with the image on its first clock edge.
  logic [7:0] ram_mem [0:65535];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= init_val(16'(i));
      ram_ready <= 1'b1;
    end else begin
      if (RAM_WE) ram_mem[RAM_A] <= RAM_D;
      if (RAM_OE) RAM_Q <= ram_mem[RAM_A];
    end
  end

  // One comparison: count it, and report it if the DUT value differs from the required one.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive both masters' request-side inputs.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                               input logic r1, input logic w1, input logic [15:0] a1, input logic [7:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Inputs change 1 ns after the active edge, and the checks happen on the falling edge.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg;
    @(negedge clk);
  endtask

  // Tenure-level reference model. It tracks who owns the RAM (-1 = nobody), how many accesses the current tenure has served, who gave the RAM up last, and which read is outstanding.
  int         m_owner, m_last, m_served, m_pend;
  logic [7:0] m_pend_data;
  logic [7:0] ref_mem [0:65535];
  logic       ref_ready = 1'b0;
  logic       e_acc, e_we, cur_req, oth_req;
  logic [15:0] e_a;
  logic [7:0]  e_d;

  // Compare process: check this cycle's outputs against the model, then step the model using the inputs the next edge will see.
  always @(negedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
      ref_ready = 1'b1;
    end
    if (rst) begin
      m_owner = -1; m_last = 1; m_served = 0; m_pend = -1;
      checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
      checkOutput("rst_RAM_WE", 32'(RAM_WE), 32'd0);
      checkOutput("rst_RAM_OE", 32'(RAM_OE), 32'd0);
      checkOutput("rst_RAM_A", 32'(RAM_A), 32'd0);
      checkOutput("rst_RAM_D", 32'(RAM_D), 32'd0);
      checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    end else begin
      cur_req = (m_owner == 0) ? m0_req : (m_owner == 1) ? m1_req : 1'b0;
      oth_req = (m_owner == 0) ? m1_req : m0_req;
      e_acc = (m_owner >= 0) && cur_req;
      e_we = 1'b0; e_a = '0; e_d = '0;
      if (e_acc) begin
        e_we = (m_owner == 0) ? m0_we : m1_we;
        e_a  = (m_owner == 0) ? m0_addr : m1_addr;
        e_d  = (m_owner == 0) ? m0_wdata : m1_wdata;
      end
      checkOutput("m0_gnt", 32'(m0_gnt), 32'(m_owner == 0));
      checkOutput("m1_gnt", 32'(m1_gnt), 32'(m_owner == 1));
      checkOutput("RAM_WE", 32'(RAM_WE), 32'(e_acc && e_we));
      checkOutput("RAM_OE", 32'(RAM_OE), 32'(e_acc && !e_we));
      checkOutput("RAM_A", 32'(RAM_A), 32'(e_a));
      checkOutput("RAM_D", 32'(RAM_D), 32'(e_d));
      checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(m_pend == 0));
      checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(m_pend == 1));
      if (m_pend >= 0) checkOutput("rdata", 32'(rdata), 32'(m_pend_data));

      if (e_acc && !e_we) begin
        m_pend = m_owner;
        m_pend_data = ref_mem[e_a];
      end else begin
        m_pend = -1;
      end
      if (e_acc && e_we) ref_mem[e_a] = e_d;

      if (m_owner < 0) begin
        m_served = 0;
        if (m0_req && m1_req) m_owner = (m_last == 1) ? 0 : 1;
        else if (m0_req)      m_owner = 0;
        else if (m1_req)      m_owner = 1;
      end else if (!cur_req) begin
        m_last   = m_owner;
        m_owner  = oth_req ? 1 - m_owner : -1;
        m_served = 0;
      end else begin
        m_served++;
        if (m_served == MB) begin
          m_served = 0;
          if (oth_req) begin
            m_last  = m_owner;
            m_owner = 1 - m_owner;
          end
        end
      end
    end
  end

  // Main sequence: directed scenarios that pin the model with literal values, then randomized traffic with occasional resets.
  initial begin
    logic r0, r1;
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    repeat (3) nextCycle;
    rst = 1'b0;
    toNeg;
    checkOutput("reset_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("reset_m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("reset_WE_OE", 32'({RAM_WE, RAM_OE}), 32'd0);
    checkOutput("reset_RAM_A", 32'(RAM_A), 32'd0);

    // m0 writes three bytes on its own.
    nextCycle; applyStimulus(1, 1, 16'h0000, 8'h11, 0, 0, 16'h0, 8'h0);
    toNeg; checkOutput("t1_no_gnt_yet", 32'(m0_gnt), 32'd0);
    nextCycle;
    toNeg; checkOutput("t1_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("t1_w0", 32'({RAM_WE, RAM_A, RAM_D}), {7'd0, 1'b1, 16'h0000, 8'h11});
    nextCycle; applyStimulus(1, 1, 16'h0001, 8'h22, 0, 0, 16'h0, 8'h0);
    toNeg; checkOutput("t1_w1", 32'({RAM_WE, RAM_A, RAM_D}), {7'd0, 1'b1, 16'h0001, 8'h22});
    nextCycle; applyStimulus(1, 1, 16'h0002, 8'h33, 0, 0, 16'h0, 8'h0);
    toNeg; checkOutput("t1_w2", 32'({RAM_WE, RAM_A, RAM_D}), {7'd0, 1'b1, 16'h0002, 8'h33});
    nextCycle; applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    toNeg; checkOutput("t1_no_access", 32'({RAM_WE, RAM_OE}), 32'd0);
    nextCycle;
    toNeg; checkOutput("t1_idle", 32'({m0_gnt, m1_gnt}), 32'd0);

    // m1 reads 0x1234 and sees 0xAB on the next cycle.
    nextCycle; applyStimulus(0, 0, 16'h0, 8'h0, 1, 0, 16'h1234, 8'h0);
    toNeg; checkOutput("t3_no_gnt_yet", 32'(m1_gnt), 32'd0);
    nextCycle;
    toNeg; checkOutput("t3_read", 32'({m1_gnt, RAM_OE, RAM_A}), {14'd0, 1'b1, 1'b1, 16'h1234});
    nextCycle; applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h1234, 8'h0);
    toNeg; checkOutput("t3_m1_rvalid", 32'(m1_rvalid), 32'd1);
    checkOutput("t3_rdata", 32'(rdata), 32'h0000_00AB);
    checkOutput("t3_m0_rvalid", 32'(m0_rvalid), 32'd0);
    nextCycle;
    toNeg; checkOutput("t5_idle", 32'({m0_gnt, m1_gnt}), 32'd0);

    // Both masters request at once. m0 wins the tie, its fourth access is a read, and the handover has no bubble.
    nextCycle; applyStimulus(1, 1, 16'h0100, 8'hC0, 1, 0, 16'h1234, 8'h00);
    toNeg; checkOutput("t2_idle", 32'(m0_gnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle;
      applyStimulus(1, (k != 3), (k == 3) ? 16'h0100 : 16'(16'h0100 + k), 8'(8'hC0 + k), 1, 0, 16'h1234, 8'h00);
      toNeg; checkOutput("t2_m0_tenure", 32'({m0_gnt, m1_gnt}), 32'd2);
    end
    nextCycle; applyStimulus(1, 1, 16'h0200, 8'h55, 1, 0, 16'h1234, 8'h00);
    toNeg; checkOutput("t4_handover", 32'({m0_gnt, m1_gnt, RAM_OE}), 32'd3);
    checkOutput("t4_m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("t4_rdata", 32'(rdata), 32'h0000_00C0);
    checkOutput("t4_m1_addr", 32'(RAM_A), 32'h0000_1234);
    repeat (3) begin
      nextCycle;
      toNeg; checkOutput("t2_m1_tenure", 32'({m0_gnt, m1_gnt}), 32'd1);
      checkOutput("t2_m1_rdata", 32'({m1_rvalid, rdata}), 32'h0000_01AB);
    end
    repeat (4) begin
      nextCycle;
      toNeg; checkOutput("t2_m0_again", 32'({m0_gnt, m1_gnt}), 32'd2);
    end
    nextCycle;
    toNeg; checkOutput("t2_m1_again", 32'({m0_gnt, m1_gnt}), 32'd1);

    // Reset arrives in the middle of m1's tenure, while its read data is pending.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    checkOutput("t6_we_oe", 32'({RAM_WE, RAM_OE}), 32'd0);
    checkOutput("t6_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    nextCycle; rst = 1'b0;
    toNeg; checkOutput("t6_idle", 32'({m0_gnt, m1_gnt}), 32'd0);
    nextCycle;
    toNeg; checkOutput("t6_tie_m0", 32'({m0_gnt, m1_gnt}), 32'd2);
    nextCycle; applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);

    // Random traffic: requests toggle rarely so both long streams and contention occur, the addresses hit a small window, and short resets happen now and then.
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nextCycle;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      applyStimulus(r0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom),
                    r1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
    end
    nextCycle; rst = 1'b0;
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    repeat (4) nextCycle;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
